// File: rtl/punc_arb_pkg.sv
// rtl/punc_arb_pkg.sv - state/owner encodings and default sizes for the PUnC memory arbiter
package punc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_DBG  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_MAX_WAIT  = 8;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CORE) ? OWN_DBG : OWN_CORE;
  endfunction

  function automatic arb_state_e owner_state(input owner_e o);
    return (o == OWN_DBG) ? ST_DBG : ST_CORE;
  endfunction

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// rtl/punc_mem_arbiter_if.sv - one requester's beat handshake and read-return bus
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = punc_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = punc_arb_pkg::DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/punc_arb_port_mux.sv
// rtl/punc_arb_port_mux.sv - steers the current owner's beat onto the memory port, zero otherwise
module punc_arb_port_mux
  import punc_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  owner_e            i_sel,
  input  logic              i_beat,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_w_en,
  output logic [DATA_W-1:0] o_mem_w_data
);

  always_comb begin
    o_mem_addr   = '0;
    o_mem_w_en   = 1'b0;
    o_mem_w_data = '0;
    if (i_beat) begin
      if (i_sel == OWN_DBG) begin
        o_mem_addr   = i_dbg_addr;
        o_mem_w_en   = i_dbg_we;
        o_mem_w_data = i_dbg_wdata;
      end else begin
        o_mem_addr   = i_core_addr;
        o_mem_w_en   = i_core_we;
        o_mem_w_data = i_core_wdata;
      end
    end
  end

endmodule

// File: rtl/punc_mem_arbiter.sv
// rtl/punc_mem_arbiter.sv - burst-aware core/debug arbiter for PUnC's single memory port
// Build option PUNC_ARB_CORE_PRIO_EN: core-priority with debug starvation limit MAX_WAIT.
module punc_mem_arbiter
  import punc_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
`ifdef PUNC_ARB_CORE_PRIO_EN
  , parameter int MAX_WAIT = DEF_MAX_WAIT
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  punc_mem_arbiter_if.slave        core_if,
  punc_mem_arbiter_if.slave        dbg_if,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic                     o_mem_w_en,
  output logic [DATA_W-1:0]        o_mem_w_data,
  input  logic [DATA_W-1:0]        i_mem_r_data
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e       r_state;
  owner_e           r_last_owner;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_core_rvalid;
  logic             r_dbg_rvalid;

  logic             w_core_gnt;
  logic             w_dbg_gnt;
  owner_e           w_owner;
  owner_e           w_tie_winner;
  logic             w_own_req;
  logic             w_oth_req;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_burst_end;
  logic             w_release;

  assign w_core_gnt  = (r_state == ST_CORE) & core_if.req;
  assign w_dbg_gnt   = (r_state == ST_DBG)  & dbg_if.req;
  assign w_owner     = (r_state == ST_DBG) ? OWN_DBG : OWN_CORE;
  assign w_own_req   = (w_owner == OWN_DBG) ? dbg_if.req  : core_if.req;
  assign w_oth_req   = (w_owner == OWN_DBG) ? core_if.req : dbg_if.req;
  assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
  assign w_burst_end = (w_cnt_inc == CNT_W'(BURST_MAX));

`ifdef PUNC_ARB_CORE_PRIO_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;

  // Core bursts are unbounded; only a starved debug side can cut them short.
  assign w_tie_winner = OWN_CORE;
  assign w_release    = w_oth_req & ((w_owner == OWN_DBG) ? w_burst_end
                                                          : (r_wait_cnt == WAIT_W'(MAX_WAIT)));

  always_ff @(posedge clk) begin
    if (rst || w_dbg_gnt) begin
      r_wait_cnt <= '0;
    end else if (dbg_if.req && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign w_tie_winner = other_owner(r_last_owner);
  assign w_release    = w_oth_req & w_burst_end;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= OWN_DBG;
      r_beat_cnt    <= '0;
      r_core_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
    end else begin
      r_core_rvalid <= w_core_gnt & ~core_if.we;
      r_dbg_rvalid  <= w_dbg_gnt & ~dbg_if.we;
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (core_if.req && dbg_if.req) begin
            r_state      <= owner_state(w_tie_winner);
            r_last_owner <= w_tie_winner;
          end else if (core_if.req) begin
            r_state      <= ST_CORE;
            r_last_owner <= OWN_CORE;
          end else if (dbg_if.req) begin
            r_state      <= ST_DBG;
            r_last_owner <= OWN_DBG;
          end
        end
        ST_CORE, ST_DBG: begin
          if (!w_own_req || w_release) begin
            r_beat_cnt <= '0;
            // Hand straight over when the other side waits, so no idle cycle is lost.
            if (w_oth_req) begin
              r_state      <= owner_state(other_owner(w_owner));
              r_last_owner <= other_owner(w_owner);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_beat_cnt <= w_burst_end ? '0 : w_cnt_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_if.gnt    = w_core_gnt;
  assign core_if.rvalid = r_core_rvalid;
  assign core_if.rdata  = r_core_rvalid ? i_mem_r_data : '0;
  assign dbg_if.gnt     = w_dbg_gnt;
  assign dbg_if.rvalid  = r_dbg_rvalid;
  assign dbg_if.rdata   = r_dbg_rvalid ? i_mem_r_data : '0;

  punc_arb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .i_sel        (w_owner),
    .i_beat       (w_core_gnt | w_dbg_gnt),
    .i_core_we    (core_if.we),
    .i_core_addr  (core_if.addr),
    .i_core_wdata (core_if.wdata),
    .i_dbg_we     (dbg_if.we),
    .i_dbg_addr   (dbg_if.addr),
    .i_dbg_wdata  (dbg_if.wdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_w_en   (o_mem_w_en),
    .o_mem_w_data (o_mem_w_data)
  );

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb/tb_punc_mem_arbiter.sv - directed and randomized checks of punc_mem_arbiter against a reference model
module tb_punc_mem_arbiter;

  localparam int BURST    = 4;
  localparam int WAIT_LIM = 8;
`ifdef PUNC_ARB_CORE_PRIO_EN
  localparam bit PRIO = 1'b1;
  localparam logic [11:0] T3_CORE = 12'hFF0;
  localparam logic [11:0] T3_DBG  = 12'h00F;
`else
  localparam bit PRIO = 1'b0;
  localparam logic [11:0] T3_CORE = 12'hF0F;
  localparam logic [11:0] T3_DBG  = 12'h0F0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) core_bus ();
  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dbg_bus ();

  logic [15:0] mem_addr;
  logic        mem_w_en;
  logic [15:0] mem_w_data;
  logic [15:0] mem_r_data;

  punc_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .core_if      (core_bus),
    .dbg_if       (dbg_bus),
    .o_mem_addr   (mem_addr),
    .o_mem_w_en   (mem_w_en),
    .o_mem_w_data (mem_w_data),
    .i_mem_r_data (mem_r_data)
  );

  // Memory array seen by the DUT (low 8 address bits select the word).
  logic [15:0] tb_mem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [15:0] pl_val;
  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_val;
    else if (mem_w_en) tb_mem[mem_addr[7:0]] <= mem_w_data;
    mem_r_data <= tb_mem[mem_addr[7:0]];
  end

  // Reference model: who owns the port, how many beats it has had, who owned it last.
  int          m_owner;
  int          m_run;
  int          m_last;
  int          m_wait;
  logic [15:0] ref_mem [256];
  bit          m_pc, m_pd;
  logic [15:0] m_pcd, m_pdd;

  int errors = 0;
  int checks = 0;

  bit          obs_cg, obs_dg, obs_crv, obs_drv, obs_wen;
  logic [15:0] obs_crd, obs_drd;
  bit          last_ec, last_ed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_advance(input bit r, input bit cr, input bit dr, input bit ec, input bit ed,
                               input bit cwe, input logic [15:0] ca, input logic [15:0] cwd,
                               input bit dwe, input logic [15:0] da, input logic [15:0] dwd);
    int  take, nxt, wait_before;
    bit  own, other, limit_hit, starve;
    if (ec) begin
      if (cwe) ref_mem[ca[7:0]] = cwd;
      else m_pcd = ref_mem[ca[7:0]];
    end
    if (ed) begin
      if (dwe) ref_mem[da[7:0]] = dwd;
      else m_pdd = ref_mem[da[7:0]];
    end
    m_pc = ec && !cwe;
    m_pd = ed && !dwe;
    if (r) begin
      m_owner = 0; m_run = 0; m_last = 2; m_wait = 0; m_pc = 0; m_pd = 0;
      return;
    end
    wait_before = m_wait;
    if (ed) m_wait = 0;
    else if (dr && m_wait < WAIT_LIM) m_wait++;
    if (m_owner == 0) begin
      if (cr && dr) take = (PRIO || m_last == 2) ? 1 : 2;
      else take = cr ? 1 : (dr ? 2 : 0);
      if (take != 0) begin
        m_owner = take; m_last = take; m_run = 0;
      end
    end else begin
      own   = (m_owner == 1) ? cr : dr;
      other = (m_owner == 1) ? dr : cr;
      nxt   = 3 - m_owner;
      if (own) m_run++;
      limit_hit = own && (m_run == BURST) && !(PRIO && m_owner == 1);
      starve    = PRIO && (m_owner == 1) && own && (wait_before >= WAIT_LIM);
      if (!own || ((limit_hit || starve) && other)) begin
        m_run   = 0;
        m_owner = other ? nxt : 0;
        if (other) m_last = nxt;
      end else if (m_run == BURST) begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input bit r,
                      input bit cr, input bit cwe, input logic [15:0] ca, input logic [15:0] cwd,
                      input bit dr, input bit dwe, input logic [15:0] da, input logic [15:0] dwd);
    bit ec, ed;
    @(negedge clk);
    rst = r;
    core_bus.req = cr; core_bus.we = cwe; core_bus.addr = ca; core_bus.wdata = cwd;
    dbg_bus.req  = dr; dbg_bus.we  = dwe; dbg_bus.addr  = da; dbg_bus.wdata  = dwd;
    #1;
    ec = (m_owner == 1) && cr;
    ed = (m_owner == 2) && dr;
    obs_cg = core_bus.gnt; obs_dg = dbg_bus.gnt; obs_wen = mem_w_en;
    obs_crv = core_bus.rvalid; obs_drv = dbg_bus.rvalid;
    obs_crd = core_bus.rdata; obs_drd = dbg_bus.rdata;
    check_eq("core_gnt", obs_cg, ec);
    check_eq("dbg_gnt", obs_dg, ed);
    check_eq("gnt_overlap", obs_cg & obs_dg, 0);
    check_eq("mem_w_en", obs_wen, (ec && cwe) || (ed && dwe));
    check_eq("mem_addr", mem_addr, ec ? ca : (ed ? da : 16'h0));
    if (ec || ed) check_eq("mem_w_data", mem_w_data, ec ? cwd : dwd);
    check_eq("core_rvalid", obs_crv, m_pc);
    check_eq("core_rdata", obs_crd, m_pc ? m_pcd : 16'h0);
    check_eq("dbg_rvalid", obs_drv, m_pd);
    check_eq("dbg_rdata", obs_drd, m_pd ? m_pdd : 16'h0);
    last_ec = ec;
    last_ed = ed;
    @(posedge clk);
    model_advance(r, cr, dr, ec, ed, cwe, ca, cwd, dwe, da, dwd);
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    int          wen_cnt, cb, db, lat;
    logic [11:0] pc, pd;
    bit          c_pend, d_pend, c_we, d_we, r;
    logic [15:0] c_a, c_d, d_a, d_d;

    rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    core_bus.req = 0; core_bus.we = 0; core_bus.addr = '0; core_bus.wdata = '0;
    dbg_bus.req  = 0; dbg_bus.we  = 0; dbg_bus.addr  = '0; dbg_bus.wdata  = '0;
    m_owner = 0; m_run = 0; m_last = 2; m_wait = 0; m_pc = 0; m_pd = 0; m_pcd = '0; m_pdd = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    @(negedge clk);
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_idx = i[7:0];
      pl_val = (i == 0) ? 16'h1234 : 16'h0000;
      @(negedge clk);
    end
    pl_en = 1'b0;
    ref_mem[0] = 16'h1234;

    // Reset state: everything quiet
    idle(1);
    idle(0);

    // 1: lone core read of 0x3000
    step(0, 1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0);
    check_eq("t1_no_gnt_c0", obs_cg, 0);
    step(0, 1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0);
    check_eq("t1_gnt_c1", obs_cg, 1);
    idle(0);
    check_eq("t1_rvalid_c2", obs_crv, 1);
    check_eq("t1_rdata_c2", obs_crd, 16'h1234);

    // 2: tie after reset, then a second tie
    idle(1);
    step(0, 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0);
    step(0, 1, 0, 16'h0001, 16'h0, 0, 0, 16'h0002, 16'h0);
    check_eq("t2_first_tie_core", obs_cg, 1);
    idle(0);
    step(0, 1, 0, 16'h0003, 16'h0, 1, 0, 16'h0004, 16'h0);
    step(0, 1, 0, 16'h0003, 16'h0, 1, 0, 16'h0004, 16'h0);
    check_eq("t2_second_tie_dbg", obs_dg, PRIO ? 0 : 1);
    check_eq("t2_second_tie_core", obs_cg, PRIO ? 1 : 0);
    idle(0);
    idle(0);

    // 4: dbg writes 0xBEEF @0x0040, core reads it back
    wen_cnt = 0;
    step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'hBEEF); wen_cnt += int'(obs_wen);
    step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'hBEEF); wen_cnt += int'(obs_wen);
    step(0, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);    wen_cnt += int'(obs_wen);
    step(0, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);    wen_cnt += int'(obs_wen);
    check_eq("t4_core_gnt", obs_cg, 1);
    idle(0); wen_cnt += int'(obs_wen);
    check_eq("t4_rvalid", obs_crv, 1);
    check_eq("t4_rdata", obs_crd, 16'hBEEF);
    check_eq("t4_w_en_cycles", wen_cnt, 1);

    // 5: reset lands on a dbg read beat
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    check_eq("t5_dbg_beat", obs_dg, 1);
    idle(0);
    check_eq("t5_no_rvalid", obs_drv, 0);
    check_eq("t5_mem_addr_zero", mem_addr, 16'h0);
    check_eq("t5_gnts_zero", {obs_cg, obs_dg}, 0);

    // 3: core wants 10 beats, dbg 8, both contending
    cb = 0; db = 0; pc = '0; pd = '0;
    for (int k = 0; k < 30; k++) begin
      step(0, cb < 10, 0, 16'h0100 + 16'(cb), 16'h0, db < 8, 0, 16'h0200 + 16'(db), 16'h0);
      if (last_ec) cb++;
      if (last_ed) db++;
      if (k >= 1 && k <= 12) begin
        pc = {pc[10:0], obs_cg};
        pd = {pd[10:0], obs_dg};
      end
    end
    check_eq("t3_core_pattern", pc, T3_CORE);
    check_eq("t3_dbg_pattern", pd, T3_DBG);

`ifdef PUNC_ARB_CORE_PRIO_EN
    // 6: dbg under continuous core traffic must get in within MAX_WAIT+1 cycles
    idle(1);
    lat = -1;
    for (int k = 0; k < 25; k++) begin
      step(0, 1, 0, 16'(k), 16'h0, k >= 3 && lat < 0, 0, 16'h0077, 16'h0);
      if (obs_dg && lat < 0) lat = k - 3;
    end
    check_eq("t6_dbg_granted", lat >= 0, 1);
    check_eq("t6_latency_le_9", lat <= 9, 1);
`endif

    // Randomized traffic honouring the requester contract
    c_pend = 0; d_pend = 0; c_we = 0; d_we = 0;
    c_a = '0; c_d = '0; d_a = '0; d_d = '0;
    for (int k = 0; k < 3000; k++) begin
      if ((c_pend && last_ec) || !c_pend) begin
        c_pend = c_pend ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        c_we = ($urandom_range(0, 2) == 0);
        c_a  = {8'($urandom), 8'($urandom_range(0, 15))};
        c_d  = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        c_pend = 0;
      end
      if ((d_pend && last_ed) || !d_pend) begin
        d_pend = d_pend ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        d_we = ($urandom_range(0, 2) == 0);
        d_a  = {8'($urandom), 8'($urandom_range(0, 15))};
        d_d  = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        d_pend = 0;
      end
      r = ($urandom_range(0, 199) == 0);
      step(r, c_pend, c_we, c_a, c_d, d_pend, d_we, d_a, d_d);
    end
    idle(0);
    idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
